// File: rtl/sm83_irq_ctl.sv
// sm83_irq_ctl: parametrised interrupt controller for the sm83 core.
// Owns IME and the delayed-EI counter, arbitrates NUM_IRQS level requests
// by fixed priority (bit 0 highest), and sequences HALT, wake and dispatch
// towards sm83_control. All outputs are registered.
module sm83_irq_ctl #(
  parameter int unsigned NUM_IRQS   = 8,
  parameter int unsigned ADR_WIDTH  = 16,
  parameter int unsigned VEC_BASE   = 'h40,
  parameter int unsigned VEC_STRIDE = 8,
  parameter int unsigned EI_DELAY   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQS-1:0]  irq,
  input  logic [NUM_IRQS-1:0]  ie,
  input  logic                 insn_end,
  input  logic                 ctl_ei,
  input  logic                 ctl_di,
  input  logic                 ctl_reti,
  input  logic                 ctl_halt,
  input  logic                 ctl_ack,
  output logic                 int_req,
  output logic [ADR_WIDTH-1:0] vector,
  output logic [NUM_IRQS-1:0]  iack,
  output logic                 halted,
  output logic                 halt_bug,
  output logic                 ime
);

  // Index width of the priority encoder; a single line still needs one bit.
  localparam int unsigned SEL_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

  // EI_DELAY is at most 3, so a 2-bit counter covers every legal setting.
  localparam logic [1:0] EI_INIT = 2'(EI_DELAY);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

  state_t               state;
  logic [1:0]           ei_cnt;
  logic [NUM_IRQS-1:0]  pend;
  logic                 any_pend;
  logic [SEL_W-1:0]     sel;
  logic [NUM_IRQS-1:0]  sel_onehot;

  // Vector of line idx; arithmetic is done at ADR_WIDTH so it wraps naturally.
  function automatic logic [ADR_WIDTH-1:0] vec_of(input logic [SEL_W-1:0] idx);
    return ADR_WIDTH'(VEC_BASE) + ADR_WIDTH'(idx) * ADR_WIDTH'(VEC_STRIDE);
  endfunction

  assign pend     = irq & ie;
  assign any_pend = |pend;

  // Fixed-priority encoder: scanning downwards lets the lowest set index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    sel = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (pend[i]) sel = SEL_W'(i);
    end
  end

  // One-hot acknowledge pattern for the winning line.
  assign sel_onehot = NUM_IRQS'(1) << sel;

  // IME / EI counter bookkeeping plus the RUN / HALT / DISPATCH sequencer.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every read in this block sees the
    // value from before the edge; that is what lets the dispatch check use
    // the old IME while the IME update lands in the same cycle.
    if (reset) begin
      // NOTE: only control state lives here, no memories, so everything is
      // reset and outputs come up at a known 0.
      state    <= ST_RUN;
      ei_cnt   <= 2'd0;
      ime      <= 1'b0;
      int_req  <= 1'b0;
      vector   <= '0;
      iack     <= '0;
      halted   <= 1'b0;
      halt_bug <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to 0 unless set below.
      iack     <= '0;
      halt_bug <= 1'b0;

      // IME sources. DI dominates EI and RETI. The EI that arrives with the
      // last T-cycle of its own instruction reloads the count, so that
      // instruction's boundary never counts towards the delay.
      if (ctl_di) begin
        ime    <= 1'b0;
        ei_cnt <= 2'd0;
      end else if (ctl_reti) begin
        ime    <= 1'b1;
        ei_cnt <= 2'd0;
      end else if (ctl_ei) begin
        ei_cnt <= EI_INIT;
        if (EI_DELAY == 0) ime <= 1'b1;
      end else if (insn_end && (state != ST_HALT) && (ei_cnt != 2'd0)) begin
        ei_cnt <= ei_cnt - 2'd1;
        if (ei_cnt == 2'd1) ime <= 1'b1;
      end

      // Sequencer. Entering DISPATCH overrides the IME update above.
      case (state)
        ST_RUN: begin
          if (insn_end && ime && any_pend) begin
            state   <= ST_DISPATCH;
            int_req <= 1'b1;
            ime     <= 1'b0;
            ei_cnt  <= 2'd0;
          end else if (ctl_halt) begin
            if (!ime && any_pend) begin
              // HALT cannot be entered; the core replays the next byte.
              halt_bug <= 1'b1;
            end else begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end
        end

        ST_HALT: begin
          // Instruction boundaries are meaningless while halted; only a
          // pending request ends the halt.
          if (any_pend) begin
            halted <= 1'b0;
            if (ime) begin
              state   <= ST_DISPATCH;
              int_req <= 1'b1;
              ime     <= 1'b0;
              ei_cnt  <= 2'd0;
            end else begin
              state <= ST_RUN;
            end
          end
        end

        ST_DISPATCH: begin
          // pend is live here: a request withdrawn before the vector-latch
          // cycle yields vector 0 and no acknowledge.
          if (ctl_ack) begin
            state   <= ST_RUN;
            int_req <= 1'b0;
            if (any_pend) begin
              vector <= vec_of(sel);
              iack   <= sel_onehot;
            end else begin
              vector <= '0;
              iack   <= '0;
            end
          end
        end

        default: begin
          state   <= ST_RUN;
          int_req <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Directed bench for sm83_irq_ctl. Expected values are queued when the
// stimulus is applied and popped in order when the outputs are sampled,
// 2 time units after the capturing clock edge.
module tb_sm83_irq_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq, ie;
  logic        insn_end, ctl_ei, ctl_di, ctl_reti, ctl_halt, ctl_ack;
  logic        int_req, halted, halt_bug, ime;
  logic [15:0] vector;
  logic [7:0]  iack;

  // Second instance: 16 lines, stride 4, sharing the control pulses.
  logic [15:0] irq_b, ie_b;
  logic        int_req_b, halted_b, halt_bug_b, ime_b;
  logic [15:0] vector_b;
  logic [15:0] iack_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sm83_irq_ctl dut (
    .clk(clk), .reset(reset), .irq(irq), .ie(ie), .insn_end(insn_end),
    .ctl_ei(ctl_ei), .ctl_di(ctl_di), .ctl_reti(ctl_reti), .ctl_halt(ctl_halt),
    .ctl_ack(ctl_ack), .int_req(int_req), .vector(vector), .iack(iack),
    .halted(halted), .halt_bug(halt_bug), .ime(ime)
  );

  sm83_irq_ctl #(.NUM_IRQS(16), .VEC_STRIDE(4)) dut_b (
    .clk(clk), .reset(reset), .irq(irq_b), .ie(ie_b), .insn_end(insn_end),
    .ctl_ei(ctl_ei), .ctl_di(ctl_di), .ctl_reti(ctl_reti), .ctl_halt(ctl_halt),
    .ctl_ack(ctl_ack), .int_req(int_req_b), .vector(vector_b), .iack(iack_b),
    .halted(halted_b), .halt_bug(halt_bug_b), .ime(ime_b)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    irq = '0; ie = '0; irq_b = '0; ie_b = '0;
    insn_end = 0; ctl_ei = 0; ctl_di = 0; ctl_reti = 0; ctl_halt = 0; ctl_ack = 0;
    tick();
    tick();
    reset = 1'b0;

    // Requests pending but IME=0: nothing happens, outputs stay at reset.
    irq = 8'h05; ie = 8'hFF;
    expect_val("rst_int_req", 0); expect_val("rst_ime", 0); expect_val("rst_halted", 0);
    expect_val("rst_vector", 0);  expect_val("rst_iack", 0); expect_val("rst_halt_bug", 0);
    tick();
    check(int_req); check(ime); check(halted); check(vector); check(iack); check(halt_bug);
    insn_end = 1;
    expect_val("ime0_no_dispatch", 0);
    tick();
    insn_end = 0;
    check(int_req);

    // RETI sets IME at once; two requests, lower index (line 2) wins.
    ctl_reti = 1;
    expect_val("reti_ime", 1);
    tick();
    ctl_reti = 0;
    check(ime);
    irq = 8'h0C; insn_end = 1;
    expect_val("reti_int_req", 1); expect_val("dispatch_clears_ime", 0);
    tick();
    insn_end = 0;
    check(int_req); check(ime);
    ctl_ack = 1;
    expect_val("vec_line2", 32'h0050); expect_val("iack_line2", 32'h04); expect_val("ack_drops_req", 0);
    tick();
    ctl_ack = 0;
    check(vector); check(iack); check(int_req);
    expect_val("iack_one_cycle", 0);
    tick();
    check(iack);
    irq = 8'h00;

    // EI with delay 1: first boundary only arms IME, second dispatches.
    ctl_ei = 1;
    expect_val("ei_ime_not_yet", 0);
    tick();
    ctl_ei = 0;
    check(ime);
    irq = 8'h01; insn_end = 1;
    expect_val("ei_first_boundary", 0); expect_val("ei_ime_set", 1);
    tick();
    insn_end = 0;
    check(int_req); check(ime);
    insn_end = 1;
    expect_val("ei_second_boundary", 1);
    tick();
    insn_end = 0;
    check(int_req);
    ctl_ack = 1;
    expect_val("vec_line0", 32'h0040); expect_val("iack_line0", 32'h01);
    tick();
    ctl_ack = 0;
    check(vector); check(iack);
    irq = 8'h00;
    tick();

    // EI and DI together: DI wins, IME never rises.
    ctl_ei = 1; ctl_di = 1;
    tick();
    ctl_ei = 0; ctl_di = 0;
    for (int k = 0; k < 3; k++) begin
      insn_end = 1;
      tick();
      insn_end = 0;
      expect_val("ei_di_ime", 0);
      tick();
      check(ime);
    end

    // HALT with IME=0 and nothing pending, then wake to RUN without dispatch.
    ctl_halt = 1;
    expect_val("halt_enter", 1); expect_val("halt_no_bug", 0);
    tick();
    ctl_halt = 0;
    check(halted); check(halt_bug);
    insn_end = 1;
    expect_val("halt_ignores_boundary", 1);
    tick();
    insn_end = 0;
    check(halted);
    irq = 8'h10; ie = 8'h10;
    expect_val("wake_halted", 0); expect_val("wake_no_req", 0);
    tick();
    check(halted); check(int_req);
    expect_val("wake_run_no_req", 0);
    tick();
    check(int_req);

    // HALT with IME=0 and a request pending: halt bug, stay in RUN.
    ctl_halt = 1;
    expect_val("halt_bug_pulse", 1); expect_val("halt_bug_not_halted", 0);
    tick();
    ctl_halt = 0;
    check(halt_bug); check(halted);
    expect_val("halt_bug_one_cycle", 0);
    tick();
    check(halt_bug);
    irq = 8'h00; ie = 8'hFF;

    // Request withdrawn inside DISPATCH: vector 0, no acknowledge.
    ctl_reti = 1;
    tick();
    ctl_reti = 0;
    irq = 8'h02; insn_end = 1;
    expect_val("wd_int_req", 1);
    tick();
    insn_end = 0;
    check(int_req);
    irq = 8'h00;
    expect_val("wd_req_held", 1);
    tick();
    check(int_req);
    ctl_ack = 1;
    expect_val("wd_vector", 0); expect_val("wd_iack", 0); expect_val("wd_req_drop", 0);
    tick();
    ctl_ack = 0;
    check(vector); check(iack); check(int_req);

    // HALT with IME=1, woken by line 3: dispatch straight from HALT.
    ctl_reti = 1;
    tick();
    ctl_reti = 0;
    ctl_halt = 1;
    expect_val("halt_ime1", 1);
    tick();
    ctl_halt = 0;
    check(halted);
    irq = 8'h08;
    expect_val("halt_wake_req", 1); expect_val("halt_wake_halted", 0);
    tick();
    check(int_req); check(halted);
    ctl_ack = 1;
    expect_val("vec_line3", 32'h0058); expect_val("iack_line3", 32'h08);
    tick();
    ctl_ack = 0;
    check(vector); check(iack);
    irq = 8'h00;

    // Reset clears the held vector; reset mid-dispatch drops int_req.
    reset = 1;
    expect_val("reset_vector", 0);
    tick();
    reset = 0;
    check(vector);
    ctl_reti = 1;
    tick();
    ctl_reti = 0;
    irq = 8'h01; irq_b = 16'h8000; ie_b = 16'hFFFF; insn_end = 1;
    expect_val("pre_reset_req", 1); expect_val("b_pre_reset_req", 1);
    tick();
    insn_end = 0;
    check(int_req); check(int_req_b);
    reset = 1;
    expect_val("reset_mid_dispatch", 0); expect_val("reset_ime", 0);
    expect_val("b_reset_req", 0); expect_val("b_reset_halted", 0); expect_val("b_reset_bug", 0);
    tick();
    reset = 0;
    check(int_req); check(ime); check(int_req_b); check(halted_b); check(halt_bug_b);

    // 16-line instance, stride 4: line 15 -> 0x40 + 15*4 = 0x7C.
    ctl_reti = 1;
    expect_val("b_ime", 1);
    tick();
    ctl_reti = 0;
    check(ime_b);
    insn_end = 1;
    tick();
    insn_end = 0;
    ctl_ack = 1;
    expect_val("b_vec_line15", 32'h007C); expect_val("b_iack_line15", 32'h8000);
    expect_val("a_vec_line0_again", 32'h0040);
    tick();
    ctl_ack = 0;
    check(vector_b); check(iack_b); check(vector);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
